bp_fe_icache_mem_responder: RTL and testbench

BP_FE_ICACHE_MEM_RESPONDER -- requirements
Module: bp_fe_icache_mem_responder

---
 rtl/bp_fe_icache_mem_responder_if.sv | 37 +++
 rtl/bp_fe_icache_mem_responder.sv | 158 +++++++++++++++
 tb/tb_bp_fe_icache_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_icache_mem_responder_if.sv
// Command/response bus between an I-cache miss engine (master) and its memory responder (slave).
// The command side is ready&valid; the response side is valid->yumi.
interface bp_fe_icache_mem_responder_if #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned block_width_p   = 512,
  parameter int unsigned payload_width_p = 16
);
  logic                       mem_cmd_v;
  logic                       mem_cmd_ready_and;
  logic [1:0]                 mem_cmd_msg_type;
  logic [paddr_width_p-1:0]   mem_cmd_addr;
  logic [2:0]                 mem_cmd_size;
  logic [payload_width_p-1:0] mem_cmd_payload;
  logic [block_width_p-1:0]   mem_cmd_data;

  logic                       mem_resp_v;
  logic                       mem_resp_yumi;
  logic [1:0]                 mem_resp_msg_type;
  logic [paddr_width_p-1:0]   mem_resp_addr;
  logic [2:0]                 mem_resp_size;
  logic [payload_width_p-1:0] mem_resp_payload;
  logic [block_width_p-1:0]   mem_resp_data;

  modport master (
    output mem_cmd_v, mem_cmd_msg_type, mem_cmd_addr, mem_cmd_size, mem_cmd_payload,
    output mem_cmd_data, mem_resp_yumi,
    input  mem_cmd_ready_and, mem_resp_v, mem_resp_msg_type, mem_resp_addr, mem_resp_size,
    input  mem_resp_payload, mem_resp_data
  );

  modport slave (
    input  mem_cmd_v, mem_cmd_msg_type, mem_cmd_addr, mem_cmd_size, mem_cmd_payload,
    input  mem_cmd_data, mem_resp_yumi,
    output mem_cmd_ready_and, mem_resp_v, mem_resp_msg_type, mem_resp_addr, mem_resp_size,
    output mem_resp_payload, mem_resp_data
  );
endinterface

// File: rtl/bp_fe_icache_mem_responder.sv
// Single-outstanding memory responder backing an I-cache with a block-organised store.
// Define BP_FE_ICACHE_MEM_RESPONDER_CHECK_EN to enable the sticky protocol-error flag.
module bp_fe_icache_mem_responder #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned block_width_p   = 512,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned els_p           = 256,
  parameter int unsigned latency_p       = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bp_fe_icache_mem_responder_if.slave   mem_if,
  output logic                          error_o
);

  localparam int unsigned block_bytes_lp    = block_width_p / 8;
  localparam int unsigned lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int unsigned lg_els_lp         = $clog2(els_p);
  localparam int unsigned cnt_width_lp      = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                      state_q, state_d;
  logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
  logic [1:0]                  type_q;
  logic [paddr_width_p-1:0]    addr_q;
  logic [2:0]                  size_q;
  logic [payload_width_p-1:0]  payload_q;
  logic [block_width_p-1:0]    data_q, data_d;

  logic                        cmd_ready, resp_v, cmd_hs, is_wr;
  logic [2:0]                  size_eff;
  logic [lg_block_bytes_lp:0]  chunk_bytes;
  logic [lg_block_bytes_lp-1:0] chunk_mask, chunk_off, src, rel;
  logic [lg_els_lp-1:0]        idx;
  logic [block_width_p-1:0]    rd_block, wr_block, rd_data;

  logic [block_width_p-1:0]    mem_q [els_p];

  assign cmd_hs = mem_if.mem_cmd_v & cmd_ready;
  assign is_wr  = mem_if.mem_cmd_msg_type[0];
  assign idx    = mem_if.mem_cmd_addr[lg_block_bytes_lp +: lg_els_lp];

  // Oversized requests are serviced as a whole-block transfer.
  assign size_eff = (mem_if.mem_cmd_size > 3'(lg_block_bytes_lp)) ? 3'(lg_block_bytes_lp)
                                                                 : mem_if.mem_cmd_size;
  assign chunk_bytes = (lg_block_bytes_lp + 1)'(1) << size_eff;
  assign chunk_mask  = lg_block_bytes_lp'(chunk_bytes - 1'b1);
  assign chunk_off   = mem_if.mem_cmd_addr[lg_block_bytes_lp-1:0] & ~chunk_mask;
  assign rd_block    = mem_q[idx];

  // Byte-granular chunk extract/replicate for reads and chunk merge for writes.
  always_comb begin
    rd_data  = '0;
    wr_block = rd_block;
    src      = '0;
    rel      = '0;
    for (int b = 0; b < block_bytes_lp; b++) begin
      src = chunk_off | (lg_block_bytes_lp'(b) & chunk_mask);
      rd_data[b*8 +: 8] = rd_block[{src, 3'b000} +: 8];
      rel = lg_block_bytes_lp'(b) - chunk_off;
      if ((lg_block_bytes_lp'(b) & ~chunk_mask) == chunk_off) begin
        wr_block[b*8 +: 8] = mem_if.mem_cmd_data[{rel, 3'b000} +: 8];
      end
    end
  end

  assign data_d = is_wr ? '0 : rd_data;

  // Backing store is deliberately not reset so completed writes survive a reset.
  always_ff @(posedge clk_i) begin
    if (cmd_hs && is_wr) begin
      mem_q[idx] <= wr_block;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      e_ready: begin
        if (cmd_hs) begin
          cnt_d   = cnt_width_lp'(latency_p);
          state_d = (latency_p == 0) ? e_resp : e_wait;
        end
      end
      e_wait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= cnt_width_lp'(1)) begin
          cnt_d   = '0;
          state_d = e_resp;
        end
      end
      e_resp: begin
        if (mem_if.mem_resp_yumi) begin
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      type_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      payload_q <= '0;
      data_q    <= '0;
    end else if (cmd_hs) begin
      type_q    <= mem_if.mem_cmd_msg_type;
      addr_q    <= mem_if.mem_cmd_addr;
      size_q    <= mem_if.mem_cmd_size;
      payload_q <= mem_if.mem_cmd_payload;
      data_q    <= data_d;
    end
  end

  always_comb begin
    cmd_ready                = (state_q == e_ready) & ~reset_i;
    resp_v                   = (state_q == e_resp) & ~reset_i;
    mem_if.mem_cmd_ready_and = cmd_ready;
    mem_if.mem_resp_v        = resp_v;
    mem_if.mem_resp_msg_type = resp_v ? type_q    : '0;
    mem_if.mem_resp_addr     = resp_v ? addr_q    : '0;
    mem_if.mem_resp_size     = resp_v ? size_q    : '0;
    mem_if.mem_resp_payload  = resp_v ? payload_q : '0;
    mem_if.mem_resp_data     = resp_v ? data_q    : '0;
  end

`ifdef BP_FE_ICACHE_MEM_RESPONDER_CHECK_EN
  logic error_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else if ((cmd_hs && (mem_if.mem_cmd_size > 3'(lg_block_bytes_lp)))
                 || (mem_if.mem_resp_yumi && !resp_v)) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// Directed bench for bp_fe_icache_mem_responder with a reference block store and an
// expected-response queue; default parameters (latency 4, 64-byte blocks, 256 blocks).
module tb_bp_fe_icache_mem_responder;

  localparam int unsigned Lat = 4;
`ifdef BP_FE_ICACHE_MEM_RESPONDER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]   t;
    logic [39:0]  a;
    logic [2:0]   sz;
    logic [15:0]  pl;
    logic [511:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i;
  logic error_o;

  int n_asserts = 0;
  int n_fail    = 0;
  logic err_exp = 1'b0;
  exp_t sb[$];
  logic [511:0] model [256];

  always #5 clk = ~clk;

  bp_fe_icache_mem_responder_if mi ();

  bp_fe_icache_mem_responder dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .mem_if  (mi.slave),
    .error_o (error_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] chunk_mask(input int nbytes);
    logic [511:0] m;
    m = '1;
    if (nbytes < 64) m = (512'd1 << (nbytes * 8)) - 512'd1;
    return m;
  endfunction

  function automatic logic [511:0] model_read(input logic [511:0] blk, input logic [5:0] off,
                                              input int sz);
    int nbytes = 1 << sz;
    int aoff   = (int'(off) / nbytes) * nbytes;
    logic [511:0] c = (blk >> (aoff * 8)) & chunk_mask(nbytes);
    logic [511:0] r = '0;
    for (int k = 0; k < 64 / nbytes; k++) r = r | (c << (k * nbytes * 8));
    return r;
  endfunction

  function automatic logic [511:0] model_write(input logic [511:0] blk, input logic [5:0] off,
                                               input int sz, input logic [511:0] d);
    int nbytes = 1 << sz;
    int aoff   = (int'(off) / nbytes) * nbytes;
    logic [511:0] m = chunk_mask(nbytes) << (aoff * 8);
    return (blk & ~m) | ((d & chunk_mask(nbytes)) << (aoff * 8));
  endfunction

  task automatic drive_cmd(input logic [1:0] t, input logic [39:0] a, input logic [2:0] sz,
                           input logic [511:0] d, input logic [15:0] pl);
    mi.mem_cmd_v        = 1'b1;
    mi.mem_cmd_msg_type = t;
    mi.mem_cmd_addr     = a;
    mi.mem_cmd_size     = sz;
    mi.mem_cmd_data     = d;
    mi.mem_cmd_payload  = pl;
  endtask

  // One full transaction: push expectation, handshake, time the response, hold, consume.
  task automatic do_txn(input logic [1:0] t, input logic [39:0] a, input logic [2:0] sz,
                        input logic [511:0] d, input logic [15:0] pl, input int hold);
    exp_t e;
    int   k;
    int   sz_eff = (sz > 3'd6) ? 6 : int'(sz);
    logic [7:0] idx = a[13:6];
    e.t  = t;
    e.a  = a;
    e.sz = sz;
    e.pl = pl;
    e.d  = t[0] ? '0 : model_read(model[idx], a[5:0], sz_eff);
    if (t[0]) model[idx] = model_write(model[idx], a[5:0], sz_eff, d);
    sb.push_back(e);

    @(negedge clk);
    drive_cmd(t, a, sz, d, pl);
    check("cmd_ready", {511'd0, mi.mem_cmd_ready_and}, 512'd1);
    @(posedge clk);
    @(negedge clk);
    mi.mem_cmd_v = 1'b0;
    if (sz > 3'd6) err_exp = ChkEn;
    check("error_next", {511'd0, error_o}, {511'd0, err_exp});
    k = 1;
    while (!mi.mem_resp_v && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("resp_latency", 512'(k), 512'(Lat + 1));
    if (!mi.mem_resp_v) return;
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("resp_v", {511'd0, mi.mem_resp_v}, 512'd1);
      check("resp_data", mi.mem_resp_data, e.d);
      check("resp_type", 512'(mi.mem_resp_msg_type), 512'(e.t));
      check("resp_addr", 512'(mi.mem_resp_addr), 512'(e.a));
      check("resp_size", 512'(mi.mem_resp_size), 512'(e.sz));
      check("resp_payload", 512'(mi.mem_resp_payload), 512'(e.pl));
      check("ready_in_resp", {511'd0, mi.mem_cmd_ready_and}, 512'd0);
    end
    mi.mem_resp_yumi = 1'b1;
    @(negedge clk);
    mi.mem_resp_yumi = 1'b0;
    check("ready_after_yumi", {511'd0, mi.mem_cmd_ready_and}, 512'd1);
    check("resp_v_after_yumi", {511'd0, mi.mem_resp_v}, 512'd0);
    check("resp_data_idle", mi.mem_resp_data, 512'd0);
  endtask

  initial begin
    logic [511:0] p0, p1;
    for (int i = 0; i < 16; i++) begin
      p0[i*32 +: 32] = 32'hC0DE_0000 + i;
      p1[i*32 +: 32] = 32'h1111_0100 + i * 3;
    end
    for (int i = 0; i < 256; i++) model[i] = '0;

    mi.mem_cmd_v     = 1'b0;
    mi.mem_resp_yumi = 1'b0;
    drive_cmd(2'd0, '0, '0, '0, '0);
    mi.mem_cmd_v = 1'b0;
    reset_i      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {511'd0, mi.mem_cmd_ready_and}, 512'd0);
    check("rst_resp_v", {511'd0, mi.mem_resp_v}, 512'd0);
    check("rst_resp_data", mi.mem_resp_data, 512'd0);
    check("rst_resp_addr", 512'(mi.mem_resp_addr), 512'd0);
    check("rst_error", {511'd0, error_o}, 512'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {511'd0, mi.mem_cmd_ready_and}, 512'd1);

    // Preload blocks 0 and 1 with full-block writes.
    do_txn(2'd1, 40'h80_0000_0040, 3'd6, p1, 16'h0101, 0);
    do_txn(2'd1, 40'h80_0000_0000, 3'd6, p0, 16'h0202, 0);
    do_txn(2'd0, 40'h80_0000_0040, 3'd6, '0, 16'hBEEF, 0);
    do_txn(2'd3, 40'h80_0000_0008, 3'd3, 512'h1122334455667788, 16'h0303, 0);
    do_txn(2'd2, 40'h80_0000_0008, 3'd3, '0, 16'h0404, 0);
    do_txn(2'd0, 40'h80_0000_0046, 3'd2, '0, 16'h0505, 0);
    do_txn(2'd2, 40'h80_0000_007F, 3'd0, '0, 16'h0606, 0);
    do_txn(2'd0, 40'h80_0000_0050, 3'd4, '0, 16'h0707, 10);
    do_txn(2'd0, 40'h80_0000_4000, 3'd6, '0, 16'h0808, 0);

    // Reset two cycles after accept: the command must vanish without a response.
    @(negedge clk);
    drive_cmd(2'd0, 40'h80_0000_0040, 3'd6, '0, 16'h0909);
    @(posedge clk);
    @(negedge clk);
    mi.mem_cmd_v = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (mi.mem_resp_v) seen++;
        @(negedge clk);
      end
      check("no_resp_after_rst", 512'(seen), 512'd0);
    end
    check("ready_post_midrst", {511'd0, mi.mem_cmd_ready_and}, 512'd1);
    do_txn(2'd0, 40'h80_0000_0040, 3'd6, '0, 16'h0A0A, 0);

    // Oversized request: serviced as a whole block, flags error when checking is built in.
    do_txn(2'd0, 40'h80_0000_0044, 3'd7, '0, 16'h0B0B, 0);
    check("error_sticky", {511'd0, error_o}, {511'd0, err_exp});

    // Stray yumi while idle is ignored.
    @(negedge clk);
    mi.mem_resp_yumi = 1'b1;
    @(negedge clk);
    mi.mem_resp_yumi = 1'b0;
    err_exp = err_exp | ChkEn;
    check("stray_yumi_resp_v", {511'd0, mi.mem_resp_v}, 512'd0);
    check("stray_yumi_ready", {511'd0, mi.mem_cmd_ready_and}, 512'd1);
    check("stray_yumi_error", {511'd0, error_o}, {511'd0, err_exp});
    do_txn(2'd2, 40'h80_0000_0010, 3'd3, '0, 16'h0C0C, 0);
    check("sb_empty", 512'(sb.size()), 512'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
